// File: rtl/mem_port_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_port_pkg
//  Description : Shared types and constants for the memory access port of the
//                downsampling processor datapath. Holds the port state
//                encoding, the control-unit memory command codes and the
//                C bus destination code used for memory writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_pkg;

    // Port sequencing states. Explicit 2-bit encoding; the fourth code is
    // unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Memory command codes driven by the control unit. 2'b11 is reserved
    // and treated exactly like CMD_IDLE.
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    // C bus destination select the control unit uses when the writeback
    // value comes from this port (cbus_data).
    localparam logic [2:0] CBUS_DST_MEM = 3'd4;

endpackage : mem_port_pkg
`default_nettype wire

// File: rtl/mem_access_port.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_port
//  Description : Consumer end of the A bus. On a read/write command from the
//                control unit the address on the A bus and the write data on
//                the B bus are captured, a level req/ack handshake is run with
//                the image/data memory, and read data is held for writeback
//                over the C bus. A request without acknowledge is abandoned
//                after TIMEOUT cycles and flagged on err.
//
//  Ports       : clock      - block clock, all state on posedge
//                rst        - synchronous active-high reset
//                abus_val   - A bus value, address source (low AW bits used)
//                bbus_val   - B bus value, write data source
//                mem_cmd    - 00 idle, 01 read, 10 write, 11 reserved
//                busy       - high whenever not IDLE
//                done       - one-cycle completion pulse (success or timeout)
//                err        - sticky timeout flag, cleared on next accept
//                cbus_data  - last read data, held until next completed read
//                mem_addr   - registered memory address
//                mem_wdata  - registered memory write data
//                mem_rd     - read request level
//                mem_wr     - write request level
//                mem_rdata  - memory read data, valid with mem_ack
//                mem_ack    - memory acknowledge
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_port
    import mem_port_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [31:0]   abus_val,
    input  logic [DW-1:0] bbus_val,
    input  logic [1:0]    mem_cmd,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] cbus_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    // Wait counter sized to hold TIMEOUT; it is cleared on every accepted
    // command and the REQ state is left at TIMEOUT-1, so it never wraps.
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_op_wr;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_cbus;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_rd;
    logic            r_wr;

    // Next-state values
    state_t          w_state_next;
    logic [CW-1:0]   w_cnt_next;
    logic            w_op_wr_next;
    logic            w_busy_next;
    logic            w_done_next;
    logic            w_err_next;
    logic [DW-1:0]   w_cbus_next;
    logic [AW-1:0]   w_addr_next;
    logic [DW-1:0]   w_wdata_next;
    logic            w_rd_next;
    logic            w_wr_next;

    logic            w_cmd_valid;
    logic            w_cmd_is_wr;

    // Only the low AW bits of the A bus form the memory address; the upper
    // bits are deliberately dropped.
    generate
        if (AW < 32) begin : g_abus_hi
            logic w_abus_hi_unused;
            assign w_abus_hi_unused = ^abus_val[31:AW];
        end
    endgenerate

    // Reserved code 2'b11 is not a valid command.
    assign w_cmd_valid = (mem_cmd == CMD_RD) || (mem_cmd == CMD_WR);
    assign w_cmd_is_wr = (mem_cmd == CMD_WR);

    // ------------------------------------------------------------------
    // State register. Every output is driven straight from a flop so the
    // memory side sees glitch-free request levels and there is no path
    // from mem_ack/mem_rdata to any output within a cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cbus  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_op_wr <= w_op_wr_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_cbus  <= w_cbus_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_rd    <= w_rd_next;
            r_wr    <= w_wr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Hold everything by default; done is a pulse so it defaults low.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_op_wr_next = r_op_wr;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        w_cbus_next  = r_cbus;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_rd_next    = r_rd;
        w_wr_next    = r_wr;

        case (r_state)
            IDLE: begin
                // mem_ack is ignored here: a late ack from an abandoned
                // access must not disturb anything.
                if (w_cmd_valid) begin
                    w_state_next = REQ;
                    w_cnt_next   = '0;
                    w_op_wr_next = w_cmd_is_wr;
                    w_addr_next  = abus_val[AW-1:0];
                    w_wdata_next = bbus_val;
                    w_err_next   = 1'b0;
                    w_busy_next  = 1'b1;
                    w_rd_next    = ~w_cmd_is_wr;
                    w_wr_next    = w_cmd_is_wr;
                end
            end

            REQ: begin
                // Ack is tested first so that an ack on the final wait
                // cycle still completes without err.
                if (mem_ack) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                    if (!r_op_wr) begin
                        w_cbus_next = mem_rdata;
                    end
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;
                    w_err_next   = 1'b1;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end

            DONE: begin
                // Commands seen here are dropped, not queued.
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end

            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
                w_rd_next    = 1'b0;
                w_wr_next    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cbus_data = r_cbus;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_rd    = r_rd;
    assign mem_wr    = r_wr;

endmodule : mem_access_port
`default_nettype wire

// File: tb/tb_mem_access_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_port
//  Description : Self-checking bench for mem_access_port. A transaction-level
//                reference (phase + cycles spent requesting) predicts every
//                output each cycle; directed sequences pin that reference with
//                literal values, then randomized commands, acks, data and
//                resets exercise the port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_port;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic          clock;
    logic          rst;
    logic [31:0]   abus_val;
    logic [DW-1:0] bbus_val;
    logic [1:0]    mem_cmd;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] cbus_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mem_access_port #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .abus_val  (abus_val),
        .bbus_val  (bbus_val),
        .mem_cmd   (mem_cmd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cbus_data (cbus_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction is either absent, being requested
    // (with a count of request cycles already elapsed), or finishing.
    // ------------------------------------------------------------------
    int            m_phase = 0;      // 0 none, 1 requesting, 2 finishing
    int            m_req_cycles;
    bit            m_is_wr;
    bit            m_started = 0;
    logic [DW-1:0] exp_cbus  = '0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic          exp_err   = 1'b0;

    always @(posedge clock) begin
        m_started = 1;
        if (rst) begin
            m_phase   = 0;
            exp_cbus  = '0;
            exp_addr  = '0;
            exp_wdata = '0;
            exp_err   = 1'b0;
        end else if (m_phase == 0) begin
            if (mem_cmd == 2'b01 || mem_cmd == 2'b10) begin
                m_phase      = 1;
                m_req_cycles = 0;
                m_is_wr      = (mem_cmd == 2'b10);
                exp_addr     = abus_val[AW-1:0];
                exp_wdata    = bbus_val;
                exp_err      = 1'b0;
            end
        end else if (m_phase == 1) begin
            m_req_cycles++;
            if (mem_ack) begin
                if (!m_is_wr) exp_cbus = mem_rdata;
                m_phase = 2;
            end else if (m_req_cycles == TIMEOUT) begin
                exp_err = 1'b1;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clock) begin
        if (m_started) begin
            chk("busy",      64'(busy),      64'(m_phase != 0));
            chk("done",      64'(done),      64'(m_phase == 2));
            chk("err",       64'(err),       64'(exp_err));
            chk("cbus_data", 64'(cbus_data), 64'(exp_cbus));
            chk("mem_addr",  64'(mem_addr),  64'(exp_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
            chk("mem_rd",    64'(mem_rd),    64'(m_phase == 1 && !m_is_wr));
            chk("mem_wr",    64'(mem_wr),    64'(m_phase == 1 && m_is_wr));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle_zero(input string nm);
        @(negedge clock);
        chk({nm, "_busy"},  64'(busy),      64'd0);
        chk({nm, "_done"},  64'(done),      64'd0);
        chk({nm, "_err"},   64'(err),       64'd0);
        chk({nm, "_cbus"},  64'(cbus_data), 64'd0);
        chk({nm, "_addr"},  64'(mem_addr),  64'd0);
        chk({nm, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({nm, "_rd"},    64'(mem_rd),    64'd0);
        chk({nm, "_wr"},    64'(mem_wr),    64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        abus_val  = '0;
        bbus_val  = '0;
        mem_cmd   = 2'b00;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk_idle_zero("reset");

        // Read, zero wait
        abus_val = 32'h0001_2345;
        mem_cmd  = 2'b01;
        tick();
        mem_cmd   = 2'b00;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("rd0_addr", 64'(mem_addr), 64'h2345);
        chk("rd0_rd",   64'(mem_rd),   64'd1);
        chk("rd0_busy", 64'(busy),     64'd1);
        tick();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("rd0_done", 64'(done),      64'd1);
        chk("rd0_cbus", 64'(cbus_data), 64'hDEAD_BEEF);
        chk("rd0_err",  64'(err),       64'd0);
        chk("rd0_rdlo", 64'(mem_rd),    64'd0);
        tick();
        @(negedge clock);
        chk("rd0_idle", 64'(busy), 64'd0);

        // Write, ack on 4th request cycle
        abus_val = 32'h0000_0010;
        bbus_val = 32'hA5A5_0F0F;
        mem_cmd  = 2'b10;
        tick();
        mem_cmd = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            mem_ack = (k == 4);
            @(negedge clock);
            chk("wr3_wr",    64'(mem_wr),    64'd1);
            chk("wr3_addr",  64'(mem_addr),  64'h10);
            chk("wr3_wdata", 64'(mem_wdata), 64'hA5A5_0F0F);
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clock);
        chk("wr3_done", 64'(done),      64'd1);
        chk("wr3_wrlo", 64'(mem_wr),    64'd0);
        chk("wr3_cbus", 64'(cbus_data), 64'hDEAD_BEEF);
        tick();

        // Timeout: no ack for TIMEOUT request cycles
        abus_val = 32'h0000_0777;
        mem_cmd  = 2'b01;
        tick();
        mem_cmd = 2'b00;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clock);
            chk("to_rd",   64'(mem_rd), 64'd1);
            chk("to_done", 64'(done),   64'd0);
            tick();
        end
        @(negedge clock);
        chk("to_done_hi", 64'(done),      64'd1);
        chk("to_err_hi",  64'(err),       64'd1);
        chk("to_rdlo",    64'(mem_rd),    64'd0);
        chk("to_cbus",    64'(cbus_data), 64'hDEAD_BEEF);
        repeat (2) tick();
        @(negedge clock);
        chk("to_err_sticky", 64'(err), 64'd1);

        // Ack on the last timeout cycle wins
        mem_cmd = 2'b01;
        tick();
        mem_cmd = 2'b00;
        @(negedge clock);
        chk("last_err_clr", 64'(err), 64'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            mem_ack   = (k == TIMEOUT);
            mem_rdata = 32'h0000_0055;
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clock);
        chk("last_done", 64'(done),      64'd1);
        chk("last_err",  64'(err),       64'd0);
        chk("last_cbus", 64'(cbus_data), 64'h55);
        tick();

        // Commands while busy are dropped
        abus_val = 32'h0000_0100;
        mem_cmd  = 2'b01;
        tick();
        mem_cmd = 2'b10;
        @(negedge clock);
        chk("busy_wr0", 64'(mem_wr), 64'd0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        @(negedge clock);
        chk("busy_wr1", 64'(mem_wr), 64'd0);
        chk("busy_rd1", 64'(mem_rd), 64'd1);
        tick();
        mem_cmd = 2'b00;
        mem_ack = 1'b0;
        @(negedge clock);
        chk("busy_done", 64'(done),      64'd1);
        chk("busy_cbus", 64'(cbus_data), 64'h1357_9BDF);
        tick();
        @(negedge clock);
        chk("busy_wr2", 64'(mem_wr), 64'd0);
        chk("busy_idle", 64'(busy),  64'd0);

        // Reset in the 2nd request cycle, late ack ignored
        abus_val = 32'h0000_0ABC;
        mem_cmd  = 2'b01;
        tick();
        mem_cmd = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        chk_idle_zero("rstmid");
        tick();
        mem_ack = 1'b0;
        chk_idle_zero("lateack");
        abus_val = 32'h0000_ABCD;
        mem_cmd  = 2'b01;
        tick();
        mem_cmd   = 2'b00;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("post_rst_done", 64'(done),      64'd1);
        chk("post_rst_cbus", 64'(cbus_data), 64'h1234_5678);
        chk("post_rst_addr", 64'(mem_addr),  64'hABCD);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            mem_cmd   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            abus_val  = $urandom;
            bbus_val  = $urandom;
            mem_rdata = $urandom;
            mem_ack   = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst     = 1'b0;
        mem_cmd = 2'b00;
        mem_ack = 1'b0;
        repeat (2) tick();
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_access_port
`default_nettype wire
